// File: rtl/tdm_pkg.sv
// tdm_pkg: shared types and constants for the 4-slot TDM demultiplexer.
package tdm_pkg;
  localparam int NSLOT = 4;
  typedef logic [1:0] slot_t;
  typedef enum logic {HUNT, LOCK} state_t;
  function automatic int ch_off(input int k, input int w);
    return k * w;
  endfunction
endpackage

// File: rtl/tdm_demux4_if.sv
// tdm_demux4_if: TDM input stream and parallel channel outputs of the demux.
interface tdm_demux4_if import tdm_pkg::*; #(parameter int WIDTH = 1);
  logic [WIDTH-1:0] din;
  logic vld;
  logic sof;
  logic [4*WIDTH-1:0] y;
  logic y_vld;
  slot_t slot;
  logic locked;
  logic sync_err;
  modport master(output din, vld, sof, input y, y_vld, slot, locked, sync_err);
  modport slave(input din, vld, sof, output y, y_vld, slot, locked, sync_err);
endinterface

// File: rtl/tdm_demux4_dec24.sv
// demux_dec24: one-hot load-enable decoder, inverse of the 4:1 slot select.
module demux_dec24 import tdm_pkg::*; (
  input  slot_t            sel,
  input  logic             en,
  output logic [NSLOT-1:0] ld
);
  assign ld = {{(NSLOT-1){1'b0}}, en} << sel;
endmodule

// File: rtl/tdm_demux4.sv
// tdm_demux4: splits a 4-slot TDM stream into four parallel channels, frame-aligned on sof.
module tdm_demux4 import tdm_pkg::*; #(parameter int WIDTH = 1) (
  input logic clk,
  input logic rst,
  tdm_demux4_if.slave bus
);
  state_t state, state_n;
  slot_t slot, slot_n;
  logic err, en;
  logic [NSLOT-1:0] ld;
  logic [NSLOT-2:0][WIDTH-1:0] shadow;
  // a sof sample always lands in shadow[0]; ld[3] doubles as the frame-complete strobe
  assign en = bus.vld & (bus.sof | (state == LOCK && slot != '0));
  demux_dec24 u_dec (.sel(bus.sof ? slot_t'(0) : slot), .en(en), .ld(ld));
  assign bus.slot = slot;
  assign bus.locked = state == LOCK;
  always_comb begin
    state_n = state;
    slot_n = slot;
    err = 1'b0;
    if (bus.vld && bus.sof) begin
      state_n = LOCK;
      slot_n = slot_t'(1);
      err = state == LOCK && slot != '0;
    end else if (bus.vld && state == LOCK) begin
      err = slot == '0;
      state_n = slot == '0 ? HUNT : LOCK;
      slot_n = slot == '0 ? slot : slot + slot_t'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HUNT;
      slot <= '0;
      shadow <= '0;
      bus.y <= '0;
      bus.y_vld <= 1'b0;
      bus.sync_err <= 1'b0;
    end else begin
      state <= state_n;
      slot <= slot_n;
      bus.y_vld <= ld[NSLOT-1];
      bus.sync_err <= err;
      for (int i = 0; i < NSLOT - 1; i++) if (ld[i]) shadow[i] <= bus.din;
      if (ld[NSLOT-1]) bus.y <= {bus.din, shadow};
    end
  end
endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: directed frames with a scoreboard monitor for y and sync_err pulses.
module tb_tdm_demux4;
  import tdm_pkg::*;
  localparam int W = 4;
  logic clk = 0;
  logic rst = 1;
  int checks = 0;
  int errors = 0;
  logic [4*W-1:0] yq[$];
  int eq[$];
  bit ychk_en = 1;
  tdm_demux4_if #(.WIDTH(W)) bus ();
  tdm_demux4 #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic cyc(input logic v, input logic s, input logic [W-1:0] d);
    bus.vld = v;
    bus.sof = s;
    bus.din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [W-1:0] a, b, c, d);
    cyc(1, 1, a);
    cyc(1, 0, b);
    cyc(1, 0, c);
    yq.push_back({d, c, b, a});
    cyc(1, 0, d);
  endtask

  always @(negedge clk) begin
    if (bus.y_vld) begin
      if (yq.size() == 0) chk("unexpected y_vld", 1, 0);
      else chk("y frame", bus.y, yq.pop_front());
      chk("y ch0 via ch_off", bus.y[ch_off(0, W) +: W], bus.y[W-1:0]);
    end
    if (bus.sync_err) begin
      if (eq.size() == 0) chk("unexpected sync_err", 1, 0);
      else chk("sync_err", 1, eq.pop_front());
    end
  end

  initial begin
    bus.vld = 0;
    bus.sof = 0;
    bus.din = '0;
    cyc(0, 0, 0);
    cyc(1, 1, 4'hF);
    rst = 0;
    chk("reset y", bus.y, 0);
    chk("reset y_vld", bus.y_vld, 0);
    chk("reset slot", bus.slot, 0);
    chk("reset locked", bus.locked, 0);
    chk("reset sync_err", bus.sync_err, 0);
    // clean frame
    frame(1, 2, 3, 4);
    chk("t1 slot", bus.slot, 0);
    chk("t1 locked", bus.locked, 1);
    cyc(0, 0, 0);
    chk("t1 y", bus.y, 16'h4321);
    chk("t1 y_vld drop", bus.y_vld, 0);
    // back-to-back
    frame(4'hA, 4'hB, 4'hC, 4'hD);
    frame(5, 6, 7, 8);
    cyc(0, 0, 0);
    chk("t2 y", bus.y, 16'h8765);
    // gaps, sof without vld ignored
    cyc(1, 1, 8);
    cyc(0, 0, 4'hF);
    chk("t3 gap slot", bus.slot, 1);
    cyc(0, 1, 4'hF);
    chk("t3 gap slot2", bus.slot, 1);
    cyc(1, 0, 6);
    cyc(1, 0, 4);
    cyc(0, 0, 0);
    chk("t3 gap slot3", bus.slot, 3);
    yq.push_back(16'h2468);
    cyc(1, 0, 2);
    cyc(0, 0, 0);
    // early sof
    cyc(1, 1, 1);
    cyc(1, 0, 2);
    eq.push_back(1);
    cyc(1, 1, 9);
    chk("t4 locked", bus.locked, 1);
    chk("t4 slot", bus.slot, 1);
    cyc(1, 0, 8);
    cyc(1, 0, 7);
    yq.push_back(16'h6789);
    cyc(1, 0, 6);
    cyc(0, 0, 0);
    // missing sof
    frame(3, 3, 3, 3);
    eq.push_back(1);
    cyc(1, 0, 5);
    chk("t5 locked", bus.locked, 0);
    chk("t5 slot", bus.slot, 0);
    cyc(1, 0, 5);
    cyc(1, 0, 5);
    chk("t5 still hunt", bus.locked, 0);
    frame(4'hA, 4'hB, 4'hC, 4'hD);
    cyc(0, 0, 0);
    chk("t5 relock y", bus.y, 16'hDCBA);
    // reset mid-frame
    cyc(1, 1, 1);
    cyc(1, 0, 2);
    chk("t6 slot", bus.slot, 2);
    rst = 1;
    cyc(1, 0, 3);
    rst = 0;
    chk("t6 y", bus.y, 0);
    chk("t6 slot0", bus.slot, 0);
    chk("t6 locked", bus.locked, 0);
    cyc(1, 0, 4);
    cyc(1, 0, 5);
    cyc(1, 0, 6);
    cyc(1, 0, 7);
    cyc(0, 0, 0);
    chk("t6 y hold", bus.y, 0);
    frame(1, 2, 3, 4);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("y queue drained", yq.size(), 0);
    chk("err queue drained", eq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
